// File: rtl/strobe_pkg.sv
// Shared constants for the strobe arbiter: FSM state encoding and stats counter width.
package strobe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARM     = 2'd1;
  localparam state_t ST_STROBE  = 2'd2;
  localparam state_t ST_RECOVER = 2'd3;

  localparam int STATS_W = 16;

endpackage

// File: rtl/strobe_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, first asserted req at ptr, ptr+1, ... wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_win,
  output logic [$clog2(NREQ)-1:0] o_win_idx,
  output logic                    o_any
);

  localparam int PW = $clog2(NREQ);

  int w_j;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    o_any     = 1'b0;
    w_j       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req[w_j]) begin
        o_win      = '0;
        o_win[w_j] = 1'b1;
        o_win_idx  = PW'(w_j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/strobe_arb.sv
// strobe_arb: round-robin owner of an edge-gated write strobe (IDLE/ARM/STROBE/RECOVER).
// Define STROBE_ARB_STATS_EN to add the 16-bit strobe_count output.
module strobe_arb
  import strobe_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int HOLD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    grant,
  output logic               gate_en,
  output logic [NREQ-1:0]    done,
`ifdef STROBE_ARB_STATS_EN
  output logic [STATS_W-1:0] strobe_count,
`endif
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  generate
    if (HOLD < 1) begin : g_hold_chk
      $error("strobe_arb: HOLD must be >= 1");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
      $error("strobe_arb: NREQ must be in 2..8");
    end
  endgenerate

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_gate;
  logic            r_busy;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_widx;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_win_idx;
  logic            w_any;
  logic [PW-1:0]   w_ptr_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  assign w_ptr_nxt = (r_widx == PW'(NREQ - 1)) ? '0 : r_widx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_widx  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_widx  <= w_win_idx;
            r_busy  <= 1'b1;
            r_state <= ST_ARM;
          end
        end
        ST_ARM: begin
          r_gate  <= 1'b1;
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          r_gate  <= 1'b0;
          r_cnt   <= CW'(HOLD - 1);
          r_state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          // Owner is held regardless of req; the sequence always runs to done.
          if (r_cnt == '0) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign gate_en = r_gate;
  assign done    = r_done;
  assign busy    = r_busy;

`ifdef STROBE_ARB_STATS_EN
  logic [STATS_W-1:0] r_strobe_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_strobe_cnt <= '0;
    else if (r_state == ST_STROBE) r_strobe_cnt <= r_strobe_cnt + 1'b1;
  end

  assign strobe_count = r_strobe_cnt;
`endif

endmodule

// File: tb/tb_strobe_arb.sv
// Self-checking bench for strobe_arb (NREQ=4, HOLD=2): timeline model plus directed literal checks.
module tb_strobe_arb;

  localparam int NREQ = 4;
  localparam int HOLD = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            gate_en;
  logic [NREQ-1:0] done;
  logic            busy;
`ifdef STROBE_ARB_STATS_EN
  logic [15:0]     strobe_count;
`endif

  int tests = 0;
  int fails = 0;
  int n     = 0;

  strobe_arb #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .gate_en (gate_en),
    .done    (done),
`ifdef STROBE_ARB_STATS_EN
    .strobe_count (strobe_count),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Timeline model: a sequence won at edge s shows grant after edges s..s+HOLD+1,
  // gate after edge s+1, done after edge s+HOLD+2; next arbitration allowed at s+HOLD+3.
  bit              m_act = 0;
  int              m_start = 0;
  int              m_ptr = 0;
  int              m_cnt = 0;
  logic [NREQ-1:0] m_win = '0;

  always @(posedge clk) begin
    int d;
    logic [NREQ-1:0] eg, ed;
    n++;
    if (!rst_n) begin
      m_act = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_act && (n - m_start) == 2) m_cnt = (m_cnt + 1) % 65536;
      if (!(m_act && (n - m_start) < HOLD + 3) && req != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          int j;
          j = (m_ptr + i) % NREQ;
          if (req[j]) begin
            m_win = '0; m_win[j] = 1'b1;
            m_ptr = (j + 1) % NREQ;
            break;
          end
        end
        m_act = 1; m_start = n;
      end
    end
    #1;
    d  = m_act ? (n - m_start) : 1000;
    eg = (d <= HOLD + 1) ? m_win : '0;
    ed = (d == HOLD + 2) ? m_win : '0;
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_gate",  32'(gate_en), 32'(d == 1));
    chk("m_done",  32'(done), 32'(ed));
    chk("m_busy",  32'(busy), 32'(d <= HOLD + 1));
`ifdef STROBE_ARB_STATS_EN
    chk("m_count", 32'(strobe_count), 32'(m_cnt));
`endif
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_gate(output logic [NREQ-1:0] g, output int cyc);
    g = '0; cyc = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (gate_en) begin g = grant; cyc = n; break; end
    end
    if (cyc < 0) begin
      tests++; fails++;
      $display("FAIL wait_gate: got timeout expected gate_en (cycle %0d)", n);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done != '0) begin seen = 1; break; end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL wait_done: got timeout expected done (cycle %0d)", n);
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!busy && done == '0) begin seen = 1; break; end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL wait_idle: got timeout expected idle (cycle %0d)", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] g [5];
    int              c [5];
    logic [NREQ-1:0] exp_c [5];
    int              ng, nd;
    exp_c = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n = 1'b0; req = '0;
    repeat (3) @(posedge clk); #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_gate",  32'(gate_en), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single request: grant 4 cycles, one gate, done on the 5th.
    @(negedge clk); req = 4'b0001;
    step(); chk("single_grant1", 32'(grant), 32'h1); chk("single_gate_arm", 32'(gate_en), 32'h0);
    step(); chk("single_gate", 32'(gate_en), 32'h1);
    step(); chk("single_rec_gate", 32'(gate_en), 32'h0); chk("single_grant3", 32'(grant), 32'h1);
    step(); chk("single_grant4", 32'(grant), 32'h1);
    step(); chk("single_done", 32'(done), 32'h1); chk("single_grant5", 32'(grant), 32'h0);
    @(negedge clk); req = '0;
    wait_idle();

    // Full contention from a fresh pointer.
    do_reset();
    @(negedge clk); req = 4'b1111;
    for (int s = 0; s < 5; s++) wait_gate(g[s], c[s]);
    @(negedge clk); req = '0;
    for (int s = 0; s < 5; s++) chk($sformatf("contend_grant%0d", s), 32'(g[s]), 32'(exp_c[s]));
    for (int s = 1; s < 5; s++) chk($sformatf("contend_period%0d", s), 32'(c[s] - c[s-1]), 32'd5);
    wait_idle();

    // Pointer wrap: serve index 2, then 1001 goes 1000 then 0001.
    @(negedge clk); req = 4'b0100;
    wait_done();
    @(negedge clk); req = 4'b1001;
    wait_gate(g[0], c[0]);
    wait_gate(g[1], c[1]);
    @(negedge clk); req = '0;
    chk("wrap_first", 32'(g[0]), 32'h8);
    chk("wrap_second", 32'(g[1]), 32'h1);
    wait_idle();

    // Reset during RECOVER aborts without done; pointer restarts at 0.
    @(negedge clk); req = 4'b0010;
    wait_gate(g[0], c[0]);
    step();
    chk("mid_rec_busy", 32'(busy), 32'h1);
    @(negedge clk); rst_n = 1'b0; req = '0;
    step();
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_busy",  32'(busy), 32'h0);
    chk("abort_done",  32'(done), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) step();
    @(negedge clk); req = 4'b0100;
    step(); chk("post_rst_grant", 32'(grant), 32'h4);
    wait_done();
    @(negedge clk); req = '0;
    wait_idle();

    // Withdrawal during ARM still completes one strobe and one done.
    @(negedge clk); req = 4'b0001;
    step(); chk("wd_grant", 32'(grant), 32'h1);
    @(negedge clk); req = '0;
    ng = 0; nd = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (gate_en) ng++;
      if (done != '0) nd++;
    end
    chk("wd_gates", 32'(ng), 32'd1);
    chk("wd_dones", 32'(nd), 32'd1);

`ifdef STROBE_ARB_STATS_EN
    // Since the last reset: the 0100 request and the withdrawn one, plus one more.
    @(negedge clk); req = 4'b1000;
    wait_done();
    @(negedge clk); req = '0;
    wait_idle();
    chk("stats_three", 32'(strobe_count), 32'd3);
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
